// File: rtl/mips_cache_pkg.sv
// Shared types, default geometry and address-split helpers for the instruction cache.
package mips_cache_pkg;

  localparam int ICACHE_XLEN       = 32;
  localparam int ICACHE_LINES      = 8;
  localparam int ICACHE_LINE_WORDS = 4;

  localparam int WSEL_W = $clog2(ICACHE_LINE_WORDS);
  localparam int OFF_W  = WSEL_W + 2;
  localparam int IDX_W  = $clog2(ICACHE_LINES);
  localparam int TAG_W  = ICACHE_XLEN - OFF_W - IDX_W;

  typedef enum logic {IDLE, REFILL} icache_state_t;

  // Word offset within the line (byte offset bits dropped).
  function automatic logic [WSEL_W-1:0] addr_off(input logic [ICACHE_XLEN-1:0] a);
    return a[2 +: WSEL_W];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ICACHE_XLEN-1:0] a);
    return a[OFF_W +: IDX_W];
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ICACHE_XLEN-1:0] a);
    return a[ICACHE_XLEN-1 -: TAG_W];
  endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage: one combinational read port, one synchronous write port.
module icache_array #(
  parameter int XLEN       = 32,
  parameter int LINES      = 8,
  parameter int LINE_WORDS = 4,
  parameter int TAG_W      = 25,
  localparam int IDX_W     = $clog2(LINES),
  localparam int WSEL_W    = $clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx_i,
  input  logic [WSEL_W-1:0] rd_wsel_i,
  output logic              rd_valid_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic [XLEN-1:0]   rd_data_o,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [WSEL_W-1:0] wr_wsel_i,
  input  logic [XLEN-1:0]   wr_data_i,
  input  logic              wr_we_i,
  input  logic              tag_we_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic              set_valid_i,
  input  logic              clr_valid_i,
  input  logic              clr_all_i
);

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [XLEN-1:0]  data_q [LINES][LINE_WORDS];

  // Valid bits: reset and full clear take priority over per-line updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (clr_all_i) begin
      valid_q <= '0;
    end else if (clr_valid_i) begin
      valid_q[wr_idx_i] <= 1'b0;
    end else if (set_valid_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag and data payload carry no reset; they are qualified by valid_q.
  always_ff @(posedge clk) begin
    if (wr_we_i) begin
      data_q[wr_idx_i][wr_wsel_i] <= wr_data_i;
    end
    if (tag_we_i) begin
      tag_q[wr_idx_i] <= wr_tag_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i][rd_wsel_i];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache with line refill, bypass and flush.
module inst_cache
  import mips_cache_pkg::*;
#(
  parameter int XLEN       = ICACHE_XLEN,
  parameter int LINES      = ICACHE_LINES,
  parameter int LINE_WORDS = ICACHE_LINE_WORDS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  input  logic            cache_en,
  input  logic            flush,
  output logic [XLEN-1:0] instruction,
  output logic            hit,
  output logic            mem_read,
  output logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready
);

  localparam int WSEL_B = $clog2(LINE_WORDS);
  localparam int OFF_B  = WSEL_B + 2;
  localparam int IDX_B  = $clog2(LINES);
  localparam int TAG_B  = XLEN - OFF_B - IDX_B;
  localparam logic [WSEL_B-1:0] LAST_BEAT = WSEL_B'(LINE_WORDS - 1);

  icache_state_t     state_q;
  logic [WSEL_B-1:0] beat_q;
  logic [TAG_B-1:0]  miss_tag_q;
  logic [IDX_B-1:0]  miss_idx_q;

  logic [TAG_B-1:0]  pc_tag;
  logic [IDX_B-1:0]  pc_idx;
  logic [WSEL_B-1:0] pc_wsel;

  logic              rd_valid;
  logic [TAG_B-1:0]  rd_tag;
  logic [XLEN-1:0]   rd_data;
  logic              lookup_hit;
  logic              last_beat;

  logic [IDX_B-1:0]  wr_idx;
  logic              wr_we;
  logic              tag_we;
  logic              set_valid;
  logic              clr_valid;
  logic              clr_all;

  assign pc_tag  = pc[XLEN-1 -: TAG_B];
  assign pc_idx  = pc[OFF_B +: IDX_B];
  assign pc_wsel = pc[2 +: WSEL_B];

  assign lookup_hit = rd_valid && (rd_tag == pc_tag);
  assign last_beat  = (beat_q == LAST_BEAT);

  icache_array #(
    .XLEN       (XLEN),
    .LINES      (LINES),
    .LINE_WORDS (LINE_WORDS),
    .TAG_W      (TAG_B)
  ) u_array (
    .clk         (clk),
    .rst         (rst),
    .rd_idx_i    (pc_idx),
    .rd_wsel_i   (pc_wsel),
    .rd_valid_o  (rd_valid),
    .rd_tag_o    (rd_tag),
    .rd_data_o   (rd_data),
    .wr_idx_i    (wr_idx),
    .wr_wsel_i   (beat_q),
    .wr_data_i   (mem_rdata),
    .wr_we_i     (wr_we),
    .tag_we_i    (tag_we),
    .wr_tag_i    (miss_tag_q),
    .set_valid_i (set_valid),
    .clr_valid_i (clr_valid),
    .clr_all_i   (clr_all)
  );

  // Array write control: invalidate on miss entry, fill beats, validate on last beat.
  always_comb begin
    wr_idx    = pc_idx;
    wr_we     = 1'b0;
    tag_we    = 1'b0;
    set_valid = 1'b0;
    clr_valid = 1'b0;
    clr_all   = 1'b0;
    if (state_q == REFILL) begin
      wr_idx = miss_idx_q;
      if (flush) begin
        clr_all = 1'b1;
      end else if (mem_ready) begin
        wr_we = 1'b1;
        if (last_beat) begin
          tag_we    = 1'b1;
          set_valid = 1'b1;
        end
      end
    end else begin
      if (flush) begin
        clr_all = 1'b1;
      end else if (cache_en && !lookup_hit) begin
        clr_valid = 1'b1;
      end
    end
  end

  // Sequencer: a flush always wins over both a new miss and an in-flight refill.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
    end else if (state_q == IDLE) begin
      if (!flush && cache_en && !lookup_hit) begin
        state_q    <= REFILL;
        beat_q     <= '0;
        miss_tag_q <= pc_tag;
        miss_idx_q <= pc_idx;
      end
    end else begin
      if (flush) begin
        state_q <= IDLE;
        beat_q  <= '0;
      end else if (mem_ready) begin
        if (last_beat) begin
          state_q <= IDLE;
          beat_q  <= '0;
        end else begin
          beat_q <= beat_q + 1'b1;
        end
      end
    end
  end

  // Fetch-side outputs: refill request, bypass pass-through, or same-cycle hit.
  always_comb begin
    hit         = 1'b0;
    instruction = '0;
    mem_read    = 1'b0;
    mem_addr    = '0;
    if (state_q == REFILL) begin
      mem_read = 1'b1;
      mem_addr = {miss_tag_q, miss_idx_q, beat_q, 2'b00};
    end else if (!cache_en) begin
      mem_read    = 1'b1;
      mem_addr    = pc & ~(XLEN'(3));
      instruction = mem_rdata;
    end else if (lookup_hit && !flush) begin
      hit         = 1'b1;
      instruction = rd_data;
    end
  end

endmodule

// File: tb/tb_inst_cache.sv
// Scoreboard bench for inst_cache: the driver predicts from a line-level model,
// monitors compare fetch results and memory requests as the DUT presents them.
module tb_inst_cache;

  localparam int LW = 4;
  localparam int NL = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        cache_en;
  logic        flush;
  logic [31:0] instruction;
  logic        hit;
  logic        mem_read;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  always #5 clk = ~clk;

  inst_cache dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .cache_en    (cache_en),
    .flush       (flush),
    .instruction (instruction),
    .hit         (hit),
    .mem_read    (mem_read),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Memory responder: each request waits stall_cfg cycles before it is accepted.
  int stall_cfg = 0;
  int beat_wait = 0;
  always @(posedge clk) begin
    if (!mem_read || mem_ready) beat_wait <= 0;
    else                        beat_wait <= beat_wait + 1;
  end
  assign mem_ready = mem_read && (beat_wait >= stall_cfg);
  assign mem_rdata = mem_word(mem_addr);

  typedef struct {
    logic [31:0] instr;
    int          waitc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] addr_q[$];
  int          total = 0;
  int          bad = 0;
  int          wait_cnt = 0;

  bit mvalid[NL];
  int mtag[NL];

  // Fetch monitor: counts stalled cycles, checks the word and latency on hit.
  always @(negedge clk) begin : mon_fetch
    exp_t e;
    if (!rst && sb.size() > 0) begin
      if (hit === 1'b1) begin
        e = sb.pop_front();
        total++;
        if (instruction !== e.instr || wait_cnt != e.waitc || mem_read !== 1'b0) begin
          bad++;
          $display("FAIL fetch pc=%h: instr=%h wait=%0d mem_read=%b, want instr=%h wait=%0d mem_read=0",
                   pc, instruction, wait_cnt, mem_read, e.instr, e.waitc);
        end
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // Memory monitor: every requesting cycle must show the next expected address.
  always @(negedge clk) begin : mon_mem
    if (!rst && mem_read === 1'b1) begin
      total++;
      if (addr_q.size() == 0) begin
        bad++;
        $display("FAIL mem_req: unexpected request addr=%h", mem_addr);
      end else if (mem_addr !== addr_q[0]) begin
        bad++;
        $display("FAIL mem_addr: got %h want %h", mem_addr, addr_q[0]);
      end
      if (mem_ready && addr_q.size() > 0) void'(addr_q.pop_front());
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NL; i++) mvalid[i] = 0;
  endtask

  // Waits for the DUT to report a hit (bounded), then steps to just after the next edge.
  task automatic wait_hit();
    int n;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (hit === 1'b1) break;
    end
    if (n == 200) begin
      total++;
      bad++;
      $display("FAIL timeout: no hit for pc=%h", pc);
      sb.delete();
      addr_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input int stall);
    int idx, tg;
    logic [31:0] base;
    idx  = int'((a >> 4) % NL);
    tg   = int'(a >> 7);
    base = a & ~32'hF;
    if (mvalid[idx] && mtag[idx] == tg) begin
      sb.push_back('{instr: mem_word(a & ~32'h3), waitc: 0});
    end else begin
      sb.push_back('{instr: mem_word(a & ~32'h3), waitc: 1 + LW * (stall + 1)});
      for (int i = 0; i < LW; i++) addr_q.push_back(base + 32'(4 * i));
      mvalid[idx] = 1;
      mtag[idx]   = tg;
    end
    stall_cfg = stall;
    cache_en  = 1'b1;
    pc        = a;
    wait_hit();
  endtask

  task automatic bypass(input logic [31:0] a);
    stall_cfg = 0;
    addr_q.push_back(a & ~32'h3);
    cache_en = 1'b0;
    pc       = a;
    @(negedge clk);
    check("bypass_instr", instruction, mem_word(a & ~32'h3));
    check("bypass_hit", {31'b0, hit}, 32'h0);
    @(posedge clk);
    #1;
    cache_en = 1'b1;
  endtask

  // Flush in IDLE while presenting pc a; neither a hit nor a refill may come of that cycle.
  task automatic flush_idle(input logic [31:0] a);
    cache_en = 1'b1;
    pc       = a;
    flush    = 1'b1;
    @(negedge clk);
    check("flush_idle_hit", {31'b0, hit}, 32'h0);
    check("flush_idle_rd", {31'b0, mem_read}, 32'h0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    model_clear();
  endtask

  // Miss on a, flush during beat 2, then the refill must restart at beat 0.
  task automatic flush_mid_refill(input logic [31:0] a);
    logic [31:0] base;
    base = a & ~32'hF;
    sb.push_back('{instr: mem_word(a & ~32'h3), waitc: 9});
    for (int i = 0; i < 3; i++)  addr_q.push_back(base + 32'(4 * i));
    for (int i = 0; i < LW; i++) addr_q.push_back(base + 32'(4 * i));
    model_clear();
    mvalid[int'((a >> 4) % NL)] = 1;
    mtag[int'((a >> 4) % NL)]   = int'(a >> 7);
    stall_cfg = 0;
    cache_en  = 1'b1;
    pc        = a;
    repeat (3) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_refill_rd", {31'b0, mem_read}, 32'h1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("after_flush_rd", {31'b0, mem_read}, 32'h0);
    wait_hit();
  endtask

  initial begin
    int r;
    logic [31:0] a;
    rst      = 1'b1;
    cache_en = 1'b1;
    flush    = 1'b0;
    pc       = 32'h0;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_hit", {31'b0, hit}, 32'h0);
    check("reset_rd", {31'b0, mem_read}, 32'h0);
    check("reset_instr", instruction, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    issue(32'h0, 0);
    issue(32'h4, 0);
    issue(32'h8, 0);
    issue(32'hC, 0);
    issue(32'h80, 0);
    issue(32'h0, 0);
    issue(32'h100, 3);
    issue(32'h104, 0);
    flush_mid_refill(32'h20);
    flush_idle(32'h20);
    issue(32'h20, 0);
    flush_idle(32'h60);
    issue(32'h60, 0);
    bypass(32'h44);
    issue(32'h44, 0);

    for (int k = 0; k < 90; k++) begin
      r = int'($urandom_range(0, 99));
      a = {22'b0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))};
      if (r < 10)      bypass(a);
      else if (r < 16) flush_idle(a);
      else             issue(a, int'($urandom_range(0, 2)));
    end

    repeat (2) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'h0);
    check("addr_drained", 32'(addr_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
